lvds_word_align: RTL



---
 rtl/lvds_align_pkg.sv | 21 ++
 rtl/lvds_pattern_cmp.sv | 41 ++++
 rtl/lvds_word_align.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lvds_align_pkg.sv
// Shared types and constants for the LVDS word-alignment trainer.
// Polarity detection is compiled in with WORD_ALIGN_POL_DETECT_EN.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } align_state_e;

  localparam logic [11:0] TRAIN_PATTERN_DEFAULT = 12'hFC0;

  // Width needed to count 0..data_w bitslips without wrapping.
  function automatic int slip_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/lvds_pattern_cmp.sv
// Registered comparison of a deserialised word against the training pattern.
// The inverted-pattern match exists only with WORD_ALIGN_POL_DETECT_EN.
module lvds_pattern_cmp
  import lvds_align_pkg::*;
#(
  parameter int                DATA_W  = 12,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(TRAIN_PATTERN_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic              match,
  output logic              match_inv
);

  logic match_d, match_q;
  logic match_inv_d, match_inv_q;

  always_comb begin
    match_d = (data_in == PATTERN);
`ifdef WORD_ALIGN_POL_DETECT_EN
    match_inv_d = (data_in == ~PATTERN);
`else
    match_inv_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      match_q     <= 1'b0;
      match_inv_q <= 1'b0;
    end else begin
      match_q     <= match_d;
      match_inv_q <= match_inv_d;
    end
  end

  assign match     = match_q;
  assign match_inv = match_inv_q;

endmodule

// File: rtl/lvds_word_align.sv
// Word-alignment trainer: issues bitslips until the training pattern lines up,
// then locks and forwards data. Optional polarity detect: WORD_ALIGN_POL_DETECT_EN.
module lvds_word_align
  import lvds_align_pkg::*;
#(
  parameter int                DATA_W        = 12,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEFAULT),
  parameter int                SLIP_WAIT     = 2,
  parameter int                LOCK_CNT      = 4,
  parameter int                LOSS_CNT      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          train_en,
  input  logic                          realign,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          bitslip,
  output logic                          locked,
  output logic                          align_err,
  output logic [slip_cnt_w(DATA_W)-1:0] slip_count,
  output logic                          pol_inv,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_out_valid
);

  localparam int SLIP_W  = slip_cnt_w(DATA_W);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);
`ifdef WORD_ALIGN_POL_DETECT_EN
  localparam bit POL_EN = 1'b1;
`else
  localparam bit POL_EN = 1'b0;
`endif

  align_state_e        state_d, state_q;
  logic [WAIT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic [MATCH_W-1:0]  match_cnt_d, match_cnt_q;
  logic [LOSS_W-1:0]   loss_cnt_d, loss_cnt_q;
  logic [SLIP_W-1:0]   slip_cnt_d, slip_cnt_q;
  logic                run_inv_d, run_inv_q;
  logic                pol_inv_d, pol_inv_q;
  logic [DATA_W-1:0]   data_out_d, data_out_q;
  logic                data_out_valid_d, data_out_valid_q;

  logic cmp_match, cmp_match_inv;
  logic hit_inv, hit_any, run_ok, lock_hit;

  lvds_pattern_cmp #(
    .DATA_W  (DATA_W),
    .PATTERN (TRAIN_PATTERN)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .match     (cmp_match),
    .match_inv (cmp_match_inv)
  );

  // A run of matches must keep the polarity of its first match.
  assign hit_inv  = cmp_match_inv & POL_EN;
  assign hit_any  = cmp_match | hit_inv;
  assign run_ok   = (match_cnt_q == '0) || (hit_inv == run_inv_q);
  assign lock_hit = pol_inv_q ? hit_inv : cmp_match;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      loss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      run_inv_q   <= 1'b0;
      pol_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      run_inv_q   <= run_inv_d;
      pol_inv_q   <= pol_inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    run_inv_d   = run_inv_q;
    pol_inv_d   = pol_inv_q;
    case (state_q)
      IDLE: begin
        if (train_en) begin
          state_d     = WAIT;
          wait_cnt_d  = WAIT_W'(SLIP_WAIT);
          match_cnt_d = '0;
          loss_cnt_d  = '0;
          slip_cnt_d  = '0;
        end
      end
      WAIT: begin
        if (!train_en) begin
          state_d = IDLE;
        end else if (wait_cnt_q <= WAIT_W'(1)) begin
          // Leave one count behind to skip the comparator's register stage.
          state_d    = CHECK;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      CHECK: begin
        if (!train_en) begin
          state_d = IDLE;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = '0;
        end else if (hit_any && run_ok) begin
          run_inv_d = hit_inv;
          if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = MATCH_W'(LOCK_CNT);
            loss_cnt_d  = '0;
            pol_inv_d   = hit_inv;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
        end else begin
          match_cnt_d = '0;
          state_d     = (slip_cnt_q == SLIP_W'(DATA_W - 1)) ? FAIL : SLIP;
        end
      end
      SLIP: begin
        slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        state_d    = train_en ? WAIT : IDLE;
        wait_cnt_d = WAIT_W'(SLIP_WAIT);
      end
      LOCKED: begin
        if (train_en) begin
          if (lock_hit) begin
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LOSS_W'(LOSS_CNT - 1)) begin
            state_d     = WAIT;
            wait_cnt_d  = WAIT_W'(SLIP_WAIT);
            match_cnt_d = '0;
            loss_cnt_d  = '0;
            slip_cnt_d  = '0;
          end else begin
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
          end
        end
      end
      FAIL: begin
        if (!train_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (realign) begin
      state_d     = train_en ? WAIT : IDLE;
      wait_cnt_d  = WAIT_W'(SLIP_WAIT);
      match_cnt_d = '0;
      loss_cnt_d  = '0;
      slip_cnt_d  = '0;
    end
    if (state_d != LOCKED) pol_inv_d = 1'b0;
  end

  always_comb begin
    bitslip   = (state_q == SLIP);
    locked    = (state_q == LOCKED);
    align_err = (state_q == FAIL);
  end

  // Output register stage: aligned word and its qualifier.
  always_comb begin
    data_out_d       = pol_inv_q ? ~data_in : data_in;
    data_out_valid_d = locked;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

  assign slip_count     = slip_cnt_q;
  assign pol_inv        = pol_inv_q;
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;

endmodule
